// File: rtl/alu_issue_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_issue_ctrl_pkg
// Purpose  : Shared definitions for the ALU issue stage: MIPS R-type funct
//            codes, the issue FSM state encoding, the decode record and the
//            legality helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_issue_ctrl_pkg;

  // Funct codes understood by the downstream TotalALU; NOP idles the ALU.
  localparam logic [5:0] FUNCT_NOP  = 6'd0;
  localparam logic [5:0] FUNCT_SRL  = 6'd2;
  localparam logic [5:0] FUNCT_MFHI = 6'd16;
  localparam logic [5:0] FUNCT_MFLO = 6'd18;
  localparam logic [5:0] FUNCT_DIVU = 6'd27;
  localparam logic [5:0] FUNCT_ADD  = 6'd32;
  localparam logic [5:0] FUNCT_SUB  = 6'd34;
  localparam logic [5:0] FUNCT_AND  = 6'd36;
  localparam logic [5:0] FUNCT_OR   = 6'd37;
  localparam logic [5:0] FUNCT_SLT  = 6'd42;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_DIV  = 3'd2,
    ST_HILO = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic legal;      // funct is in the supported set
    logic is_div;     // multi-cycle DIVU path
    logic wen;        // result is written to a GPR
    logic use_shamt;  // operands come from rt and shamt (SRL)
  } decode_t;

  function automatic logic is_legal_funct(input logic [5:0] funct);
    case (funct)
      FUNCT_AND, FUNCT_OR, FUNCT_ADD, FUNCT_SUB, FUNCT_SRL,
      FUNCT_SLT, FUNCT_DIVU, FUNCT_MFHI, FUNCT_MFLO: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : alu_issue_ctrl_if
// Purpose  : Bundles the issue-stage buses: op input handshake, ALU drive /
//            sample signals, and the result output handshake.
// Ports    : in_*  - decoded op offered by the upstream (valid/ready)
//            alu_* - dataA/dataB/Signal to the ALU, Output back from it
//            out_* - result towards the consumer (valid/ready)
//            modport slave  : the issue controller's view
//            modport master : the surrounding environment's view
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alu_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs;
  logic [31:0] in_rt;

  logic [31:0] alu_dataA;
  logic [31:0] alu_dataB;
  logic [5:0]  alu_signal;
  logic [31:0] alu_output;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_wen;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_funct, in_shamt, in_rs, in_rt, alu_output, out_ready,
    output in_ready, alu_dataA, alu_dataB, alu_signal,
           out_valid, out_data, out_wen, out_illegal
  );

  modport master (
    output in_valid, in_funct, in_shamt, in_rs, in_rt, alu_output, out_ready,
    input  in_ready, alu_dataA, alu_dataB, alu_signal,
           out_valid, out_data, out_wen, out_illegal
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl_decode.sv
//------------------------------------------------------------------------------
// Module   : alu_issue_ctrl_decode
// Purpose  : Combinational classification of an incoming funct code.
// Ports    : funct (in, 6)  - MIPS funct field
//            dec   (out)    - {legal, is_div, wen, use_shamt}
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue_ctrl_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output decode_t    dec
);

  logic legal;
  logic is_div;

  assign legal  = is_legal_funct(funct);
  assign is_div = (funct == FUNCT_DIVU);

  assign dec.legal     = legal;
  assign dec.is_div    = is_div;
  // DIVU only updates HI/LO, so it never writes a GPR.
  assign dec.wen       = legal && !is_div;
  assign dec.use_shamt = (funct == FUNCT_SRL);

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
//------------------------------------------------------------------------------
// Module   : alu_issue_ctrl
// Purpose  : Issue stage in front of the TotalALU. Accepts one R-type op,
//            drives dataA/dataB/Signal for the op's latency, samples the ALU
//            Output and presents the result with a write-enable flag. DIVU is
//            followed by a HI/LO settle phase so later MFHI/MFLO read stable
//            values.
// Ports    : clk   (in)  - rising-edge clock
//            reset (in)  - asynchronous, active-high
//            bus   (slave modport of alu_issue_ctrl_if) - op in, ALU, result out
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int ALU_LAT    = 1,
  parameter int DIV_CYCLES = 32,
  parameter int HILO_LAT   = 1
) (
  input  logic            clk,
  input  logic            reset,
  alu_issue_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] HILO_CNT = CNT_W'(HILO_LAT);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;
  logic             capture;
  logic [5:0]       signal_nxt;

  logic [5:0]       funct_q;
  logic [31:0]      data_a;
  logic [31:0]      data_b;
  logic [31:0]      result;
  logic             wen_q;
  logic             illegal_q;

  decode_t          dec;

  alu_issue_ctrl_decode u_decode (
    .funct (bus.in_funct),
    .dec   (dec)
  );

  // State and phase counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter and handshake/ALU drive. The "cnt <= 1" tests end
  // each phase on its last cycle and keep the counter from wrapping below 0.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    accept       = 1'b0;
    capture      = 1'b0;
    signal_nxt   = FUNCT_NOP;
    bus.in_ready = 1'b0;

    case (state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept = 1'b1;
          if (!dec.legal) begin
            state_nxt = ST_DONE;
            cnt_nxt   = '0;
          end else if (dec.is_div) begin
            state_nxt = ST_DIV;
            cnt_nxt   = DIV_CNT;
          end else begin
            state_nxt = ST_EXEC;
            cnt_nxt   = ALU_CNT;
          end
        end
      end

      ST_EXEC: begin
        signal_nxt = funct_q;
        if (cnt <= 1) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      ST_DIV: begin
        signal_nxt = FUNCT_DIVU;
        if (cnt <= 1) begin
          state_nxt = ST_HILO;
          cnt_nxt   = HILO_CNT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      ST_HILO: begin
        if (cnt <= 1) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Operand and result registers. The result is cleared on every accept so
  // DIVU and illegal ops retire with out_data = 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      funct_q   <= FUNCT_NOP;
      data_a    <= '0;
      data_b    <= '0;
      result    <= '0;
      wen_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        funct_q   <= bus.in_funct;
        data_a    <= dec.use_shamt ? bus.in_rt : bus.in_rs;
        data_b    <= dec.use_shamt ? {27'b0, bus.in_shamt} : bus.in_rt;
        result    <= '0;
        wen_q     <= dec.wen;
        illegal_q <= !dec.legal;
      end
      if (capture) begin
        result <= bus.alu_output;
      end
    end
  end

  // Signal is decoded from the live state so an asynchronous reset forces
  // NOP immediately; operands simply hold their last values.
  assign bus.alu_signal  = signal_nxt;
  assign bus.alu_dataA   = data_a;
  assign bus.alu_dataB   = data_b;

  // Result outputs are visible only while a result is being offered.
  assign bus.out_valid   = (state == ST_DONE);
  assign bus.out_data    = (state == ST_DONE) ? result : 32'd0;
  assign bus.out_wen     = (state == ST_DONE) && wen_q;
  assign bus.out_illegal = (state == ST_DONE) && illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_issue_ctrl
// Purpose  : Self-checking bench for alu_issue_ctrl: a behavioural TotalALU
//            stand-in, a directed vector table, randomized ops scored against
//            a reference model, plus backpressure and mid-DIVU reset sequences.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_ctrl;

  localparam int ALU_LAT    = 1;
  localparam int DIV_CYCLES = 32;
  localparam int HILO_LAT   = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_ctrl_if ifc ();

  alu_issue_ctrl #(
    .ALU_LAT    (ALU_LAT),
    .DIV_CYCLES (DIV_CYCLES),
    .HILO_LAT   (HILO_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural ALU stand-in ----------------
  logic [31:0] alu_hi;
  logic [31:0] alu_lo;

  always_comb begin
    case (ifc.alu_signal)
      6'd36:   ifc.alu_output = ifc.alu_dataA & ifc.alu_dataB;
      6'd37:   ifc.alu_output = ifc.alu_dataA | ifc.alu_dataB;
      6'd32:   ifc.alu_output = ifc.alu_dataA + ifc.alu_dataB;
      6'd34:   ifc.alu_output = ifc.alu_dataA - ifc.alu_dataB;
      6'd42:   ifc.alu_output = ($signed(ifc.alu_dataA) < $signed(ifc.alu_dataB)) ? 32'd1 : 32'd0;
      6'd2:    ifc.alu_output = ifc.alu_dataA >> ifc.alu_dataB;
      6'd16:   ifc.alu_output = alu_hi;
      6'd18:   ifc.alu_output = alu_lo;
      default: ifc.alu_output = 32'hDEAD_BEEF;
    endcase
  end

  always @(posedge clk) begin
    if (reset) begin
      alu_hi <= 32'd0;
      alu_lo <= 32'd0;
    end else if (ifc.alu_signal == 6'd27) begin
      if (ifc.alu_dataB == 32'd0) begin
        alu_hi <= ifc.alu_dataA;
        alu_lo <= 32'hFFFF_FFFF;
      end else begin
        alu_hi <= ifc.alu_dataA % ifc.alu_dataB;
        alu_lo <= ifc.alu_dataA / ifc.alu_dataB;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  function automatic bit tb_legal(input logic [5:0] f);
    return f inside {6'd2, 6'd16, 6'd18, 6'd27, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
  endfunction

  task automatic model(input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt,
                       output logic [31:0] d, output logic w, output logic il);
    d = 32'd0; w = 1'b1; il = 1'b0;
    case (f)
      6'd36: d = rs & rt;
      6'd37: d = rs | rt;
      6'd32: d = rs + rt;
      6'd34: d = rs - rt;
      6'd42: d = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
      6'd2:  d = rt >> sh;
      6'd16: d = m_hi;
      6'd18: d = m_lo;
      6'd27: begin
        w = 1'b0;
        if (rt == 32'd0) begin m_hi = rs; m_lo = 32'hFFFF_FFFF; end
        else begin m_hi = rs % rt; m_lo = rs / rt; end
      end
      default: begin w = 1'b0; il = 1'b1; end
    endcase
  endtask

  // Edges after the accept edge until out_valid, and cycles Signal is non-NOP.
  function automatic int exp_lat(input logic [5:0] f);
    if (!tb_legal(f)) return 0;
    if (f == 6'd27)   return DIV_CYCLES + HILO_LAT;
    return ALU_LAT;
  endfunction

  function automatic int exp_sig(input logic [5:0] f);
    if (!tb_legal(f)) return 0;
    if (f == 6'd27)   return DIV_CYCLES;
    return ALU_LAT;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Issue one op, follow it through to retirement and check every phase.
  task automatic do_op(input string tag, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] ed, input logic ew, input logic eil, input int bp);
    int          n;
    int          sig;
    logic        bad;
    logic        unstable;
    logic [31:0] a0;
    logic [31:0] b0;

    n = 0;
    while (!ifc.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, " in_ready before accept"}, 32'(ifc.in_ready), 32'd1);

    ifc.in_funct = f; ifc.in_shamt = sh; ifc.in_rs = rs; ifc.in_rt = rt;
    ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    // Scramble the input bus: the DUT must work from its registered copy.
    ifc.in_rs = $urandom; ifc.in_rt = $urandom; ifc.in_funct = 6'(($urandom));
    ifc.in_shamt = 5'($urandom);

    n = 0; sig = 0; bad = 1'b0;
    a0 = ifc.alu_dataA; b0 = ifc.alu_dataB;
    while (!ifc.out_valid && n < 100) begin
      if (ifc.alu_signal != 6'd0) begin
        sig++;
        if (ifc.alu_signal != f) bad = 1'b1;
      end
      if (ifc.in_ready) bad = 1'b1;
      @(posedge clk); #1; n++;
    end
    chk({tag, " latency"},          32'(n),   32'(exp_lat(f)));
    chk({tag, " signal cycles"},    32'(sig), 32'(exp_sig(f)));
    chk({tag, " busy signal/ready"}, 32'(bad), 32'd0);
    chk({tag, " dataA"}, a0, (f == 6'd2) ? rt : rs);
    chk({tag, " dataB"}, b0, (f == 6'd2) ? {27'd0, sh} : rt);
    chk({tag, " out_data"},    ifc.out_data,          ed);
    chk({tag, " out_wen"},     32'(ifc.out_wen),      32'(ew));
    chk({tag, " out_illegal"}, 32'(ifc.out_illegal),  32'(eil));
    chk({tag, " done in_ready"}, 32'(ifc.in_ready),   32'd0);
    chk({tag, " done signal"},   32'(ifc.alu_signal), 32'd0);

    unstable = 1'b0;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      if (!ifc.out_valid || ifc.out_data !== ed || ifc.out_wen !== ew ||
          ifc.in_ready || ifc.alu_signal != 6'd0) unstable = 1'b1;
    end
    if (bp > 0) chk({tag, " held under backpressure"}, 32'(unstable), 32'd0);

    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    chk({tag, " retired out_valid"}, 32'(ifc.out_valid), 32'd0);
    chk({tag, " retired in_ready"},  32'(ifc.in_ready),  32'd1);
  endtask

  typedef struct {
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_data;
    logic        exp_wen;
    logic        exp_ill;
    int          bp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        w;
    logic        il;
    logic [5:0]  f;
    int          k;

    tbl[0] = '{6'd32, 5'd0, 32'd5,          32'd7,          32'd12,         1'b1, 1'b0, 0};
    tbl[1] = '{6'd2,  5'd4, 32'h1234_5678,  32'h8000_0000,  32'h0800_0000,  1'b1, 1'b0, 0};
    tbl[2] = '{6'd27, 5'd0, 32'd100,        32'd7,          32'd0,          1'b0, 1'b0, 0};
    tbl[3] = '{6'd16, 5'd0, 32'd0,          32'd0,          32'd2,          1'b1, 1'b0, 0};
    tbl[4] = '{6'd18, 5'd0, 32'd0,          32'd0,          32'd14,         1'b1, 1'b0, 0};
    tbl[5] = '{6'd34, 5'd0, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b1, 1'b0, 10};
    tbl[6] = '{6'd63, 5'd0, 32'd9,          32'd9,          32'd0,          1'b0, 1'b1, 0};
    tbl[7] = '{6'd42, 5'd0, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b1, 1'b0, 0};
    tbl[8] = '{6'd36, 5'd0, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b1, 1'b0, 0};

    ifc.in_valid = 1'b0; ifc.in_funct = 6'd0; ifc.in_shamt = 5'd0;
    ifc.in_rs = 32'd0; ifc.in_rt = 32'd0; ifc.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready",    32'(ifc.in_ready),    32'd1);
    chk("reset out_valid",   32'(ifc.out_valid),   32'd0);
    chk("reset alu_signal",  32'(ifc.alu_signal),  32'd0);
    chk("reset dataA",       ifc.alu_dataA,        32'd0);
    chk("reset dataB",       ifc.alu_dataB,        32'd0);
    chk("reset out_data",    ifc.out_data,         32'd0);
    chk("reset out_wen",     32'(ifc.out_wen),     32'd0);
    chk("reset out_illegal", 32'(ifc.out_illegal), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table; the model runs alongside only to track HI/LO.
    foreach (tbl[i]) begin
      model(tbl[i].funct, tbl[i].shamt, tbl[i].rs, tbl[i].rt, d, w, il);
      do_op($sformatf("vec%0d", i), tbl[i].funct, tbl[i].shamt, tbl[i].rs, tbl[i].rt,
            tbl[i].exp_data, tbl[i].exp_wen, tbl[i].exp_ill, tbl[i].bp);
    end

    // Reset during the tenth DIVU cycle.
    ifc.in_funct = 6'd27; ifc.in_rs = 32'd1000; ifc.in_rt = 32'd3; ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    k = 0;
    for (int i = 1; i < 10; i++) begin
      if (ifc.alu_signal != 6'd27) k++;
      @(posedge clk); #1;
    end
    chk("rst-mid-div DIVU held", 32'(k), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst-mid-div signal",    32'(ifc.alu_signal), 32'd0);
    chk("rst-mid-div in_ready",  32'(ifc.in_ready),   32'd1);
    chk("rst-mid-div out_valid", 32'(ifc.out_valid),  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    @(posedge clk); #1;
    do_op("post-reset OR", 6'd37, 5'd0, 32'h0000_00F0, 32'h0000_000F,
          32'h0000_00FF, 1'b1, 1'b0, 0);

    // Randomized ops scored against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [5:0]  legal_list [9];
      logic [31:0] rs;
      logic [31:0] rt;
      logic [4:0]  sh;
      legal_list = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd2, 6'd42, 6'd27, 6'd16, 6'd18};
      k = int'($urandom_range(0, 9));
      if (k < 9) f = legal_list[k];
      else begin
        f = 6'($urandom_range(0, 63));
        while (tb_legal(f)) f = 6'($urandom_range(0, 63));
      end
      rs = $urandom; rt = $urandom; sh = 5'($urandom);
      if (f == 6'd27 && ($urandom_range(0, 1) == 0)) rt = 32'($urandom_range(1, 50));
      model(f, sh, rs, rt, d, w, il);
      do_op($sformatf("rnd%0d f%0d", i, f), f, sh, rs, rt, d, w, il,
            int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
